// File: rtl/range_counter.sv
// +----------------------------------------------------------------------------+
// | range_counter: up/down counter bounded to [LO,HI] with clamped load,        |
// | terminal-count pulse and saturating wrap tally.                             |
// | Option: define RANGE_COUNTER_SATURATE_EN to hold at the bounds instead of   |
// | wrapping (tc then flags each blocked step).                                 |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module range_counter #(
  parameter int WIDTH = 8,
  parameter int LO    = 18,
  parameter int HI    = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [15:0]      wraps
);

  localparam logic [WIDTH-1:0] c_lo        = WIDTH'(LO);
  localparam logic [WIDTH-1:0] c_hi        = WIDTH'(HI);
  localparam logic [15:0]      c_wraps_max = 16'hFFFF;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [15:0]      r_wraps;

  logic             w_below;
  logic             w_above;
  logic [WIDTH-1:0] w_clamp;
  logic             w_at_hi;
  logic             w_at_lo;

  // Bounds at the edges of the WIDTH range need no clamp; skipping the
  // compare avoids a constant-result comparison.
  if (LO == 0) begin : g_no_lo_clamp
    assign w_below = 1'b0;
  end else begin : g_lo_clamp
    assign w_below = (load_val < c_lo);
  end

  if (HI == (2 ** WIDTH) - 1) begin : g_no_hi_clamp
    assign w_above = 1'b0;
  end else begin : g_hi_clamp
    assign w_above = (load_val > c_hi);
  end

  assign w_clamp = w_below ? c_lo : (w_above ? c_hi : load_val);
  assign w_at_hi = (r_count == c_hi);
  assign w_at_lo = (r_count == c_lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_lo;
      r_tc    <= 1'b0;
      r_wraps <= 16'd0;
    end else if (load) begin
      r_count <= w_clamp;
      r_tc    <= 1'b0;
    end else if (en) begin
      // Bound is tested before stepping, so +/-1 never leaves [LO,HI].
      if ((up && w_at_hi) || (!up && w_at_lo)) begin
        r_tc <= 1'b1;
`ifdef RANGE_COUNTER_SATURATE_EN
        r_count <= r_count;
`else
        r_count <= up ? c_lo : c_hi;
        if (r_wraps != c_wraps_max) begin
          r_wraps <= r_wraps + 16'd1;
        end
`endif
      end else begin
        r_count <= up ? (r_count + 1'b1) : (r_count - 1'b1);
        r_tc    <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign wraps = r_wraps;

endmodule

`default_nettype wire

// File: doc/range_counter.md
# range_counter

Parametrised bounded-range counter. It counts between a programmable low bound LO and high bound HI, up or down, with enable, synchronous load, a terminal-count pulse and a wrap-event tally. It generalises the team's fixed 18..27 wrap counter and sits in sequencer and timing-generator paths that need a reusable modulo-N stage with arbitrary offset.

## Interface
Parameters:
- WIDTH, 8, bit width of `count` and `load_val`.
- LO, 18, lower bound and reset value of `count`.
- HI, 27, upper bound.
- Legal range: 0 <= LO <= HI <= 2^WIDTH-1. LO == HI is legal; the counter then always holds LO.

Ports (single clock; reset is asynchronous, active-high):
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  load value; clamped into [LO,HI].
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- wraps  output  16  number of wrap events since reset; saturates at 16'hFFFF.

## Operation
- Reset (rst=1, any time, no clock needed): count=LO, tc=0, wraps=0. State is held while rst is high.
- Per rising edge, with rst low, the priority is load > en > hold.
- Load (load=1):
  - count = LO if load_val < LO, HI if load_val > HI, otherwise load_val.
  - tc=0; wraps unchanged; en and up are ignored that cycle.
- Count up (load=0, en=1, up=1):
  - If count < HI: count+1, tc=0.
  - If count == HI: wrap event. count=LO, tc=1, wraps+1 (saturating).
- Count down (load=0, en=1, up=0):
  - If count > LO: count-1, tc=0.
  - If count == LO: wrap event. count=HI, tc=1, wraps+1 (saturating).
- Hold (load=0, en=0): count and wraps unchanged; tc=0.
- LO == HI: every enabled edge is a wrap event. count stays at LO, tc=1, wraps increments.
- Arithmetic:
  - Comparisons are unsigned at WIDTH bits.
  - The ±1 step never overflows, because the bounds are checked first.
  - HI = 2^WIDTH-1 and LO = 0 must work with no out-of-range intermediate value.
- Direction may change on any cycle. Each step uses the `up` value sampled at that edge.

## Timing
- Latency: inputs are sampled at edge N; count, tc and wraps reflect them after edge N. There is no combinational input-to-output path.
- tc is high for exactly the one cycle following a wrap edge. Back-to-back wraps (for example LO==HI, or an up/down toggle at a bound) give tc high on consecutive cycles.
- Asserting rst mid-count forces outputs to reset values immediately, asynchronously. The first count step after release happens on the first rising edge with rst low.
- Load and en asserted together: the load wins and no step occurs.

## Configuration
- Macro: RANGE_COUNTER_SATURATE_EN.
- Not defined (default): wrap behaviour as described above.
- Defined (saturate mode):
  - At a bound, an enabled step in the outward direction holds count at that bound and does not increment wraps.
  - tc=1 for each such blocked step, so tc means "limit hit".
  - Steps inward from a bound behave normally.
  - Load, hold and reset are unchanged.

## Test plan
- Reset and count up: rst=1 then 0, en=1, up=1 for 10 edges. Required: count 18 → 19..27 → 18. tc high only in the cycle count first reads 18 after 27. wraps=1.
- Count down from reset: en=1, up=0. Required: count 18 → 27 on the first edge, tc=1, wraps=1; then 26, 25, … with tc=0.
- Load clamp: load 40 gives count=27; load 5 gives count=18; load 22 gives count=22. Load=1 with en=1 in the same cycle applies the load with no step, and tc stays 0 throughout.
- Hold and asynchronous reset: en=0 for 5 edges keeps count constant. Pulsing rst between edges at count=24 drops count to 18 and wraps to 0 without waiting for a clock edge.
- Boundary parameters: WIDTH=4, LO=0, HI=15 with up counting gives 15 → 0, tc=1. LO=HI=5 gives count stuck at 5, with tc and wraps incrementing every enabled edge. Drive 70000 wraps and check wraps holds at 16'hFFFF.
- RANGE_COUNTER_SATURATE_EN defined: counting up past 27 holds 27 with tc=1 on each enabled edge and wraps=0. Then up=0 gives 26 with tc=0.
